// File: rtl/sram_access_ctrl_if.sv
// Request/response and SRAM bus bundle for sram_access_ctrl.
// master = datapath side plus SRAM model, slave = the controller.
interface sram_access_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        op_code;
    logic [ADDR_W-1:0] address_one;
    logic [ADDR_W-1:0] address_two;
    logic [DATA_W-1:0] data_in;
    logic              rsp_valid;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_read_en;
    logic              sram_write_en;
    logic              busy;

    modport master (
        output req_valid, op_code, address_one, address_two, data_in, sram_rdata,
        input  req_ready, rsp_valid, data_out, sram_addr, sram_wdata,
               sram_read_en, sram_write_en, busy
    );

    modport slave (
        input  req_valid, op_code, address_one, address_two, data_in, sram_rdata,
        output req_ready, rsp_valid, data_out, sram_addr, sram_wdata,
               sram_read_en, sram_write_en, busy
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Single-access SRAM sequencer: turns one datapath request into timed read/write
// strobes and reports completion with a one-cycle rsp_valid pulse.
module sram_access_ctrl #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic n_rst,
    sram_access_ctrl_if.slave bus
);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        COPY_RD,
        COPY_WR,
        DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] addr_one;
    logic [ADDR_W-1:0] addr_two;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              accept;
    logic              last_cycle;
    logic              in_access;
    logic              read_en;
    logic              write_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    assign accept     = (state == IDLE) && bus.req_valid;
    assign last_cycle = (count == LAST);
    assign in_access  = (state == READ) || (state == WRITE) ||
                        (state == COPY_RD) || (state == COPY_WR);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The state itself carries the latched opcode, so no separate op register is kept.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    case (bus.op_code)
                        2'b01:   next_state = READ;
                        2'b10:   next_state = WRITE;
                        2'b11:   next_state = COPY_RD;
                        default: next_state = DONE;
                    endcase
                end
            end
            READ:    if (last_cycle) next_state = DONE;
            WRITE:   if (last_cycle) next_state = DONE;
            COPY_RD: if (last_cycle) next_state = COPY_WR;
            COPY_WR: if (last_cycle) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count    <= '0;
            addr_one <= '0;
            addr_two <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                addr_one <= bus.address_one;
                addr_two <= bus.address_two;
                wdata_q  <= bus.data_in;
            end
            if (in_access) begin
                if (last_cycle) begin
                    count <= '0;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else begin
                count <= '0;
            end
            if (((state == READ) || (state == COPY_RD)) && last_cycle) begin
                rdata_q <= bus.sram_rdata;
            end
        end
    end

    // SRAM strobes decode from state only; IDLE and DONE drive everything to zero.
    always_comb begin
        read_en  = 1'b0;
        write_en = 1'b0;
        addr     = '0;
        wdata    = '0;
        case (state)
            READ, COPY_RD: begin
                read_en = 1'b1;
                addr    = addr_one;
            end
            WRITE: begin
                write_en = 1'b1;
                addr     = addr_one;
                wdata    = wdata_q;
            end
            COPY_WR: begin
                write_en = 1'b1;
                addr     = addr_two;
                wdata    = rdata_q;
            end
            default: begin
                read_en  = 1'b0;
                write_en = 1'b0;
            end
        endcase
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.rsp_valid     = (state == DONE);
    assign bus.data_out      = rdata_q;
    assign bus.sram_read_en  = read_en;
    assign bus.sram_write_en = write_en;
    assign bus.sram_addr     = addr;
    assign bus.sram_wdata    = wdata;
endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
Sequencer sitting directly downstream of the datapath block. It accepts one datapath request at a time (op_code, address_one, address_two, data_in) and turns it into timed SRAM read/write strobes. It returns read or copied data on data_out with a one-cycle response strobe. It executes exactly one SRAM access at a time and never issues overlapping read and write strobes.

Parameters:
ADDR_W, 7, SRAM word address width (matches address_one/address_two)
DATA_W, 32, SRAM word width
WAIT_CYCLES, 2, cycles each SRAM access holds its enable (>=1); internal counter width = max(1, clog2(WAIT_CYCLES))

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller idle, request accepted on clk edge when req_valid&&req_ready
op_code  in  2  00 NOP, 01 READ, 10 WRITE, 11 COPY
address_one  in  ADDR_W  source / target address
address_two  in  ADDR_W  COPY destination address
data_in  in  DATA_W  WRITE data
rsp_valid  out  1  one-cycle completion strobe
data_out  out  DATA_W  last captured read word
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  DATA_W  SRAM write data
sram_rdata  in  DATA_W  SRAM read data
sram_read_en  out  1  SRAM read strobe
sram_write_en  out  1  SRAM write strobe
busy  out  1  ~req_ready

Behaviour:
- Reset (async, n_rst=0): state IDLE, counter 0, all latched request fields 0. req_ready=1, busy=0, rsp_valid=0, data_out=0, sram_addr=0, sram_wdata=0, sram_read_en=0, sram_write_en=0. Strobes drop immediately on reset assertion, including mid-access. No completion is reported for the aborted request.
- States: IDLE, READ, WRITE, COPY_RD, COPY_WR, DONE. All outputs are registered or decoded from state only, with no combinational path from request inputs.
- IDLE: req_ready=1. On an accept edge, latch op_code, address_one, address_two and data_in. Go to READ (01), WRITE (10), COPY_RD (11) or DONE (00). Request inputs are ignored in every other state.
- READ / COPY_RD: sram_read_en=1, sram_addr=latched address_one, for exactly WAIT_CYCLES cycles.
  - On the edge ending the last cycle (counter==WAIT_CYCLES-1), capture sram_rdata into the data register and reset the counter.
  - READ then goes to DONE. COPY_RD goes to COPY_WR.
- WRITE: sram_write_en=1, sram_addr=latched address_one, sram_wdata=latched data_in, for WAIT_CYCLES cycles, then DONE.
- COPY_WR: sram_write_en=1, sram_addr=latched address_two, sram_wdata=captured word, for WAIT_CYCLES cycles, then DONE.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE. req_ready stays 0 during DONE, so back-to-back requests are spaced by at least one IDLE cycle.
- Latency from accept edge to the rsp_valid cycle: NOP 1, READ/WRITE WAIT_CYCLES+1, COPY 2*WAIT_CYCLES+1.
- Strobe invariants:
  - sram_read_en and sram_write_en are never both 1.
  - In IDLE/DONE both strobes are 0, sram_addr=0 and sram_wdata=0.
  - Strobes are contiguous: no gap between COPY_RD and COPY_WR except the state change itself (back-to-back cycles).
- data_out:
  - Updates only on a read capture and holds its value otherwise, including across WRITE and NOP.
  - During COPY, data_out updates at the capture and equals the copied word at rsp_valid.
- COPY with address_one==address_two is legal: it reads then rewrites the same word.
- Address wrap-around is not applicable: addresses are used verbatim with no increment.

Test Plan:
- Reset mid-READ (n_rst low in 2nd READ cycle) -> sram_read_en drops the same cycle with no clock edge needed; req_ready=1; rsp_valid never pulses; data_out=0.
- WRITE op 10, address_one=0x05, data_in=0xDEADBEEF (W=2) -> sram_write_en=1, addr 0x05, wdata 0xDEADBEEF for 2 cycles; rsp_valid at cycle 3 after accept; data_out unchanged.
- READ op 01, address_one=0x05, SRAM model returns 0xDEADBEEF -> sram_read_en 2 cycles at 0x05; rsp_valid at cycle 3; data_out=0xDEADBEEF and holds after.
- COPY op 11, address_one=0x10 (holds 0x12345678), address_two=0x7F -> read 0x10 for 2 cycles, then write 0x7F with 0x12345678 for 2 cycles; rsp_valid at cycle 5; data_out=0x12345678.
- NOP op 00 -> no strobes; rsp_valid 1 cycle after accept; req_ready low exactly 1 cycle.
- req_valid held high with changing inputs during a COPY -> inputs ignored until req_ready returns; next accept occurs on the first IDLE edge; strobes are never simultaneously high.
